// File: rtl/opl3_dac_pkg.sv
// Shared constants, FSM state type and the gain/saturation helper for the OPL3 DAC feeder.
// The helper is the only place that defines how the synth sample is scaled and clipped.
package opl3_dac_pkg;

    localparam logic [7:0]         UNITY_GAIN = 8'd128;
    localparam int                 GAIN_SHIFT = $clog2(UNITY_GAIN);
    localparam logic signed [15:0] SAT_MAX    = 16'sh7FFF;
    localparam logic signed [15:0] SAT_MIN    = 16'sh8000;
    localparam logic [15:0]        ZERO_S     = 16'h0000;
    localparam logic [15:0]        ZERO_U     = 16'h8000;

    typedef enum logic [0:0] {
        ST_PREFILL = 1'b0,
        ST_RUN     = 1'b1
    } feeder_state_t;

    // 24 bits hold the full product because |sample * volume| < 2**23.
    function automatic logic [15:0] apply_gain(input logic signed [15:0] sample,
                                               input logic [7:0]         volume);
        logic signed [23:0] prod;
        logic signed [23:0] shifted;
        logic [15:0]        result;
        prod    = $signed({{8{sample[15]}}, sample}) * $signed({16'd0, volume});
        shifted = prod >>> GAIN_SHIFT;
        if (shifted > 24'(SAT_MAX)) begin
            result = SAT_MAX;
        end else if (shifted < 24'(SAT_MIN)) begin
            result = SAT_MIN;
        end else begin
            result = shifted[15:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/opl3_dac_feeder_if.sv
// Valid/ready stereo sample channel from the OPL3 synth core into the DAC feeder.
interface opl3_dac_feeder_if;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_left;
    logic [15:0] in_right;

    modport master (
        output in_valid,
        output in_left,
        output in_right,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_left,
        input  in_right,
        output in_ready
    );

endinterface

// File: rtl/stereo_fifo.sv
// Circular FIFO of left/right sample pairs ({left, right} in one 32-bit word).
// Pointers wrap naturally through their DEPTH_LOG2 width; level counts up to 2**DEPTH_LOG2.
module stereo_fifo #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  i_push,
    input  logic [31:0]           i_push_data,
    input  logic                  i_pop,
    output logic [31:0]           o_pop_data,
    output logic [DEPTH_LOG2:0]   o_level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0]           r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;

    // Storage array, cleared on reset so no stale audio survives it.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'h0000_0000;
            end
        end else if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves level unchanged.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_wr_ptr <= {DEPTH_LOG2{1'b0}};
            r_rd_ptr <= {DEPTH_LOG2{1'b0}};
            r_level  <= {(DEPTH_LOG2+1){1'b0}};
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
            end
            case ({i_push, i_pop})
                2'b10:   r_level <= r_level + {{DEPTH_LOG2{1'b0}}, 1'b1};
                2'b01:   r_level <= r_level - {{DEPTH_LOG2{1'b0}}, 1'b1};
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_pop_data = r_mem[r_rd_ptr];
    assign o_level    = r_level;

endmodule

// File: rtl/opl3_dac_feeder.sv
// Buffers gain-scaled OPL3 stereo samples and hands one pair to the I2S DAC driver
// on every falling edge of its (asynchronous) lrck, with prefill and underrun recovery.
module opl3_dac_feeder
    import opl3_dac_pkg::*;
#(
    parameter int DEPTH_LOG2    = 3,
    parameter bit OFFSET_BINARY = 1'b1,
    parameter int PREFILL       = 4
) (
    input  logic                  clk,
    input  logic                  arst,
    opl3_dac_feeder_if.slave      s_in,
    input  logic [7:0]            i_volume,
    input  logic                  i_lrck,
    output logic [15:0]           o_left,
    output logic [15:0]           o_right,
    output logic                  o_sample_tick,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_running,
    output logic [15:0]           o_underrun_cnt
);

    localparam logic [DEPTH_LOG2+1:0] DEPTH_W   = (DEPTH_LOG2+2)'(1 << DEPTH_LOG2);
    localparam logic [DEPTH_LOG2:0]   PREFILL_W = (DEPTH_LOG2+1)'(PREFILL);
    localparam logic [15:0]           ZERO_LVL  = OFFSET_BINARY ? ZERO_U : ZERO_S;
    localparam logic [15:0]           OUT_XOR   = OFFSET_BINARY ? 16'h8000 : 16'h0000;

    logic                  r_gain_valid;
    logic [15:0]           r_gain_l;
    logic [15:0]           r_gain_r;
    logic                  r_lrck_s1;
    logic                  r_lrck_s2;
    logic                  r_lrck_d;
    feeder_state_t         r_state;
    feeder_state_t         w_state_nxt;
    logic [15:0]           r_left;
    logic [15:0]           r_right;
    logic                  r_tick;
    logic [15:0]           r_underrun_cnt;
    logic [DEPTH_LOG2:0]   w_level;
    logic [DEPTH_LOG2+1:0] w_occupancy;
    logic [31:0]           w_pop_data;
    logic                  w_accept;
    logic                  w_req;
    logic                  w_pop;
    logic                  w_load;
    logic                  w_zero;
    logic                  w_underrun;

    // Counting the sample held in the gain stage keeps a full FIFO from ever losing it.
    assign w_occupancy   = {1'b0, w_level} + {{(DEPTH_LOG2+1){1'b0}}, r_gain_valid};
    assign s_in.in_ready = (w_occupancy < DEPTH_W);
    assign w_accept      = s_in.in_valid & s_in.in_ready;

    // Gain stage: volume is sampled at accept time, so later changes never touch queued audio.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_gain_valid <= 1'b0;
            r_gain_l     <= 16'h0000;
            r_gain_r     <= 16'h0000;
        end else begin
            r_gain_valid <= w_accept;
            if (w_accept) begin
                r_gain_l <= apply_gain(s_in.in_left, i_volume);
                r_gain_r <= apply_gain(s_in.in_right, i_volume);
            end
        end
    end

    stereo_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk         (clk),
        .arst        (arst),
        .i_push      (r_gain_valid),
        .i_push_data ({r_gain_l, r_gain_r}),
        .i_pop       (w_pop),
        .o_pop_data  (w_pop_data),
        .o_level     (w_level)
    );

    // lrck synchroniser plus a delay stage for falling-edge detection.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_lrck_s1 <= 1'b0;
            r_lrck_s2 <= 1'b0;
            r_lrck_d  <= 1'b0;
        end else begin
            r_lrck_s1 <= i_lrck;
            r_lrck_s2 <= r_lrck_s1;
            r_lrck_d  <= r_lrck_s2;
        end
    end

    assign w_req = r_lrck_d & ~r_lrck_s2;

    // FSM state register.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= ST_PREFILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-request action; a pop is only ever issued with level > 0.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_zero      = 1'b0;
        w_underrun  = 1'b0;
        case (r_state)
            ST_PREFILL: begin
                if (w_req) begin
                    if (w_level >= PREFILL_W) begin
                        w_pop       = 1'b1;
                        w_load      = 1'b1;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_zero = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_PREFILL;
                end
            end
            ST_RUN: begin
                if (w_req) begin
                    if (w_level != {(DEPTH_LOG2+1){1'b0}}) begin
                        w_pop  = 1'b1;
                        w_load = 1'b1;
                    end else begin
                        w_underrun  = 1'b1;
                        w_state_nxt = ST_PREFILL;
                    end
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_PREFILL;
            end
        endcase
    end

    // Output registers: DAC sample pair, request tick and saturating underrun count.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_left         <= ZERO_LVL;
            r_right        <= ZERO_LVL;
            r_tick         <= 1'b0;
            r_underrun_cnt <= 16'h0000;
        end else begin
            r_tick <= w_req;
            if (w_load) begin
                r_left  <= w_pop_data[31:16] ^ OUT_XOR;
                r_right <= w_pop_data[15:0] ^ OUT_XOR;
            end else if (w_zero) begin
                r_left  <= ZERO_LVL;
                r_right <= ZERO_LVL;
            end
            if (w_underrun && (r_underrun_cnt != 16'hFFFF)) begin
                r_underrun_cnt <= r_underrun_cnt + 16'd1;
            end
        end
    end

    assign o_left         = r_left;
    assign o_right        = r_right;
    assign o_sample_tick  = r_tick;
    assign o_level        = w_level;
    assign o_running      = (r_state == ST_RUN);
    assign o_underrun_cnt = r_underrun_cnt;

endmodule

// File: tb/tb_opl3_dac_feeder.sv
// Scoreboard bench for opl3_dac_feeder: accepted samples are gain-modelled into a queue,
// and each lrck fall is checked against a behavioural prefill/run/underrun model.
module tb_opl3_dac_feeder;

    logic        clk;
    logic        arst;
    logic [7:0]  volume;
    logic        lrck;
    logic [15:0] left;
    logic [15:0] right;
    logic        tick;
    logic [3:0]  level;
    logic        running;
    logic [15:0] underrun_cnt;

    opl3_dac_feeder_if bus ();

    opl3_dac_feeder #(
        .DEPTH_LOG2    (3),
        .OFFSET_BINARY (1'b1),
        .PREFILL       (4)
    ) dut (
        .clk            (clk),
        .arst           (arst),
        .s_in           (bus),
        .i_volume       (volume),
        .i_lrck         (lrck),
        .o_left         (left),
        .o_right        (right),
        .o_sample_tick  (tick),
        .o_level        (level),
        .o_running      (running),
        .o_underrun_cnt (underrun_cnt)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          tick_cnt = 0;
    logic [31:0] sb_q[$];
    bit          m_run;
    logic [15:0] m_left;
    logic [15:0] m_right;
    int          m_under;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tick) tick_cnt <= tick_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] model_gain(input logic [15:0] s, input logic [7:0] v);
        int p;
        p = int'($signed(s)) * int'({24'd0, v});
        p = p >>> 7;
        if (p > 32767) p = 32767;
        else if (p < -32768) p = -32768;
        return 16'(p) ^ 16'h8000;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_run   = 1'b0;
        m_left  = 16'h8000;
        m_right = 16'h8000;
        m_under = 0;
    endtask

    task automatic do_reset();
        arst         = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_left  = 16'h0000;
        bus.in_right = 16'h0000;
        lrck         = 1'b0;
        repeat (3) step();
        arst = 1'b0;
        model_reset();
        step();
    endtask

    task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
        int w;
        w = 0;
        bus.in_left  = l;
        bus.in_right = r;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && w < 40) begin
            step();
            w++;
        end
        check_eq("push_accept", {31'd0, bus.in_ready}, 32'd1);
        if (bus.in_ready) sb_q.push_back({model_gain(l, volume), model_gain(r, volume)});
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic lrck_fall(input bit chk_level);
        int          w;
        bit          got;
        logic [31:0] e;
        lrck = 1'b1;
        repeat (3) step();
        lrck = 1'b0;
        w    = 0;
        got  = 1'b0;
        while (w < 6 && !got) begin
            @(negedge clk);
            w++;
            if (tick) got = 1'b1;
        end
        check_eq("tick_seen", {31'd0, got}, 32'd1);
        check_eq("tick_latency_le4", {31'd0, (w <= 4)}, 32'd1);
        if (!m_run) begin
            if (sb_q.size() >= 4) begin
                e       = sb_q.pop_front();
                m_left  = e[31:16];
                m_right = e[15:0];
                m_run   = 1'b1;
            end else begin
                m_left  = 16'h8000;
                m_right = 16'h8000;
            end
        end else begin
            if (sb_q.size() > 0) begin
                e       = sb_q.pop_front();
                m_left  = e[31:16];
                m_right = e[15:0];
            end else begin
                m_under++;
                m_run = 1'b0;
            end
        end
        check_eq("left", {16'd0, left}, {16'd0, m_left});
        check_eq("right", {16'd0, right}, {16'd0, m_right});
        check_eq("running", {31'd0, running}, {31'd0, m_run});
        check_eq("underrun_cnt", {16'd0, underrun_cnt}, 32'(m_under));
        if (chk_level) check_eq("level", {28'd0, level}, 32'(sb_q.size()));
        step();
    endtask

    initial begin
        int t0;
        volume = 8'd128;
        do_reset();

        // Reset state, then prefill behaviour with nothing buffered.
        check_eq("rst_ready", {31'd0, bus.in_ready}, 32'd1);
        check_eq("rst_level", {28'd0, level}, 32'd0);
        check_eq("rst_running", {31'd0, running}, 32'd0);
        check_eq("rst_left", {16'd0, left}, 32'h8000);
        check_eq("rst_right", {16'd0, right}, 32'h8000);
        t0 = tick_cnt;
        repeat (3) lrck_fall(1'b1);
        check_eq("idle_ticks", 32'(tick_cnt - t0), 32'd3);
        check_eq("idle_underrun", {16'd0, underrun_cnt}, 32'd0);

        // Unity gain, prefill, drain, then underrun with held output.
        repeat (4) push_pair(16'h1234, 16'hFFFE);
        lrck_fall(1'b1);
        check_eq("unity_left", {16'd0, left}, 32'h9234);
        check_eq("unity_right", {16'd0, right}, 32'h7FFE);
        repeat (4) lrck_fall(1'b1);
        check_eq("underrun_hold_left", {16'd0, left}, 32'h9234);
        check_eq("underrun_one", {16'd0, underrun_cnt}, 32'd1);

        // Saturation and volume changes between samples.
        do_reset();
        volume = 8'd255;
        push_pair(16'h7000, 16'h9000);
        volume = 8'd64;
        push_pair(16'h4000, 16'hC000);
        volume = 8'd255;
        push_pair(16'h9000, 16'h7000);
        volume = 8'd128;
        push_pair(16'h0001, 16'hFFFF);
        lrck_fall(1'b1);
        check_eq("sat_pos", {16'd0, left}, 32'hFFFF);
        check_eq("sat_neg", {16'd0, right}, 32'h0000);
        repeat (4) lrck_fall(1'b1);

        // Backpressure: fill completely, stall, release one slot per pop.
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            logic [15:0] s;
            s = 16'(i * 256 + i);
            push_pair(s, -s);
        end
        repeat (3) step();
        check_eq("full_level", {28'd0, level}, 32'd8);
        check_eq("full_ready", {31'd0, bus.in_ready}, 32'd0);
        fork
            push_pair(16'h5A5A, 16'hA5A5);
            lrck_fall(1'b0);
        join
        repeat (3) step();
        check_eq("refill_level", {28'd0, level}, 32'd8);
        repeat (9) lrck_fall(1'b1);
        check_eq("drain_underrun", {16'd0, underrun_cnt}, 32'd1);

        // Reset in the middle of RUN discards everything.
        do_reset();
        for (int i = 0; i < 6; i++) push_pair(16'(16'h0300 + i), 16'(16'h0700 - i));
        lrck_fall(1'b1);
        check_eq("pre_rst_level", {28'd0, level}, 32'd5);
        arst = 1'b1;
        #2;
        check_eq("mid_rst_level", {28'd0, level}, 32'd0);
        check_eq("mid_rst_left", {16'd0, left}, 32'h8000);
        check_eq("mid_rst_running", {31'd0, running}, 32'd0);
        repeat (2) step();
        t0   = tick_cnt;
        arst = 1'b0;
        model_reset();
        repeat (4) step();
        check_eq("no_spurious_tick", 32'(tick_cnt - t0), 32'd0);
        lrck_fall(1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
